unidade_controle_jogo: RTL and testbench

- Control FSM for the memory-sequence game datapath: counters for jogada address (E) and rodada (R), the move register, the comparator, and the rodada-limit detect.
- Sequences one game from iniciar to a win, an error or a timeout.
- Detects the rising edge of the datapath's tem_jogada level.
- Owns the per-move timeout counter.
- Instantiated beside the datapath inside the top-level game circuit.

---
 rtl/jogo_pkg.sv | 44 ++++
 rtl/contador_timeout.sv | 28 ++
 rtl/unidade_controle_jogo.sv | 141 ++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared state codes and control-output decode for the memory-sequence game controller.
// The hex-display decoder and the bench also use these state codes.
package jogo_pkg;

    localparam int ESTADO_W = 4;

    localparam logic [ESTADO_W-1:0] INICIAL       = 4'h0;
    localparam logic [ESTADO_W-1:0] PREPARA       = 4'h1;
    localparam logic [ESTADO_W-1:0] INICIO_RODADA = 4'h2;
    localparam logic [ESTADO_W-1:0] ESPERA        = 4'h3;
    localparam logic [ESTADO_W-1:0] REGISTRA      = 4'h4;
    localparam logic [ESTADO_W-1:0] COMPARA       = 4'h5;
    localparam logic [ESTADO_W-1:0] PROX_JOGADA   = 4'h6;
    localparam logic [ESTADO_W-1:0] PROX_RODADA   = 4'h7;
    localparam logic [ESTADO_W-1:0] FIM_GANHOU    = 4'hA;
    localparam logic [ESTADO_W-1:0] FIM_TIMEOUT   = 4'hD;
    localparam logic [ESTADO_W-1:0] FIM_PERDEU    = 4'hE;

    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_r;
        logic conta_r;
        logic registra_r;
        logic pronto;
    } controle_t;

    // Moore decode of the datapath control lines for a given state.
    function automatic controle_t decodifica(logic [ESTADO_W-1:0] estado);
        controle_t c;
        c = '0;
        case (estado)
            PREPARA:       begin c.zera_e = 1'b1; c.zera_r = 1'b1; end
            INICIO_RODADA: c.zera_e     = 1'b1;
            REGISTRA:      c.registra_r = 1'b1;
            PROX_JOGADA:   c.conta_e    = 1'b1;
            PROX_RODADA:   c.conta_r    = 1'b1;
            FIM_GANHOU, FIM_TIMEOUT, FIM_PERDEU: c.pronto = 1'b1;
            default:       c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// Per-move timeout counter: cleared by zera, counts while conta, saturates at TIMEOUT_CICLOS-1.
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 3000,
    parameter int TIMER_W        = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam logic [TIMER_W-1:0] ULTIMO = TIMER_W'(TIMEOUT_CICLOS - 1);

    logic [TIMER_W-1:0] contagem;

    // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clock) begin
        if (!reset || zera) begin
            contagem <= '0;
        end else if (conta && contagem != ULTIMO) begin
            contagem <= contagem + TIMER_W'(1);
        end
    end

    assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Control FSM for the memory-sequence game: sequences one game from iniciar to win, error or timeout.
// Macro UNIDADE_CONTROLE_TIMEOUT_EN adds the per-move timer and the FIM_TIMEOUT exit from ESPERA.
module unidade_controle_jogo
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 3000,
    parameter int TIMER_W        = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                jogada,
    input  logic                igual,
    input  logic                enderecoIgualRodada,
    input  logic                fimRodadas,
    output logic                zeraE,
    output logic                contaE,
    output logic                zeraR,
    output logic                contaR,
    output logic                registraR,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                db_timeout,
    output logic [ESTADO_W-1:0] db_estado
);

    typedef enum logic [ESTADO_W-1:0] {
        S_INICIAL       = INICIAL,
        S_PREPARA       = PREPARA,
        S_INICIO_RODADA = INICIO_RODADA,
        S_ESPERA        = ESPERA,
        S_REGISTRA      = REGISTRA,
        S_COMPARA       = COMPARA,
        S_PROX_JOGADA   = PROX_JOGADA,
        S_PROX_RODADA   = PROX_RODADA,
        S_FIM_GANHOU    = FIM_GANHOU,
        S_FIM_TIMEOUT   = FIM_TIMEOUT,
        S_FIM_PERDEU    = FIM_PERDEU
    } estado_t;

    if (2**TIMER_W < TIMEOUT_CICLOS) begin : g_timer_w_invalido
        $error("TIMER_W too narrow for TIMEOUT_CICLOS");
    end

    estado_t   estado;
    estado_t   proximo;
    controle_t ctrl;
    logic      jogada_d;
    logic      jp;

    // One pulse per press, however long the button is held.
    assign jp = jogada & ~jogada_d;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    logic timer_fim;

    contador_timeout #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
        .TIMER_W       (TIMER_W)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .zera (estado != S_ESPERA),
        .conta(estado == S_ESPERA),
        .fim  (timer_fim)
    );
`endif

    always_comb begin
        // NOTE: default assignment first so no path leaves proximo unassigned (no latch).
        proximo = estado;
        case (estado)
            S_INICIAL:       if (iniciar) proximo = S_PREPARA;
            S_PREPARA:       proximo = S_INICIO_RODADA;
            S_INICIO_RODADA: proximo = S_ESPERA;
            S_ESPERA: begin
                if (jp) proximo = S_REGISTRA;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
                else if (timer_fim) proximo = S_FIM_TIMEOUT;
`endif
            end
            S_REGISTRA:      proximo = S_COMPARA;
            S_COMPARA: begin
                if (!igual)                                   proximo = S_FIM_PERDEU;
                else if (enderecoIgualRodada && fimRodadas)   proximo = S_FIM_GANHOU;
                else if (enderecoIgualRodada)                 proximo = S_PROX_RODADA;
                else                                          proximo = S_PROX_JOGADA;
            end
            S_PROX_JOGADA:   proximo = S_ESPERA;
            S_PROX_RODADA:   proximo = S_INICIO_RODADA;
            S_FIM_GANHOU, S_FIM_TIMEOUT, S_FIM_PERDEU:
                             if (iniciar) proximo = S_PREPARA;
            default:         proximo = S_INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy matches the current state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado   <= S_INICIAL;
            jogada_d <= 1'b0;
            ctrl     <= '0;
            ganhou   <= 1'b0;
            perdeu   <= 1'b0;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
            db_timeout <= 1'b0;
`endif
        end else begin
            estado   <= proximo;
            jogada_d <= jogada;
            ctrl     <= decodifica(proximo);
            if (proximo == S_PREPARA) begin
                ganhou <= 1'b0;
                perdeu <= 1'b0;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
                db_timeout <= 1'b0;
`endif
            end else begin
                if (proximo == S_FIM_GANHOU) ganhou <= 1'b1;
                if (proximo == S_FIM_PERDEU || proximo == S_FIM_TIMEOUT) perdeu <= 1'b1;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
                if (proximo == S_FIM_TIMEOUT) db_timeout <= 1'b1;
`endif
            end
        end
    end

`ifndef UNIDADE_CONTROLE_TIMEOUT_EN
    assign db_timeout = 1'b0;
`endif

    assign zeraE     = ctrl.zera_e;
    assign contaE    = ctrl.conta_e;
    assign zeraR     = ctrl.zera_r;
    assign contaR    = ctrl.conta_r;
    assign registraR = ctrl.registra_r;
    assign pronto    = ctrl.pronto;
    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Scoreboard bench for unidade_controle_jogo: stimulus queues the expected state path,
// a monitor compares every state change (full output vector and, where given, dwell time).
module tb_unidade_controle_jogo;
    import jogo_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b0;
    logic       eir = 1'b0;
    logic       fim_r = 1'b0;
    logic       zeraE, contaE, zeraR, contaR, registraR, pronto;
    logic       ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;

    unidade_controle_jogo #(
        .TIMEOUT_CICLOS(20),
        .TIMER_W       (5)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .jogada             (jogada),
        .igual              (igual),
        .enderecoIgualRodada(eir),
        .fimRodadas         (fim_r),
        .zeraE              (zeraE),
        .contaE             (contaE),
        .zeraR              (zeraR),
        .contaR             (contaR),
        .registraR          (registraR),
        .pronto             (pronto),
        .ganhou             (ganhou),
        .perdeu             (perdeu),
        .db_timeout         (db_timeout),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    int ciclo = 0;
    always @(posedge clock) ciclo++;

    typedef struct {
        logic [12:0] vec;
        int          dt;
        string       nome;
    } esperado_t;

    esperado_t fila[$];
    int  checks = 0;
    int  failures = 0;
    bit  m_g = 1'b0, m_p = 1'b0, m_t = 1'b0;

    // Expected {zeraE, contaE, zeraR, contaR, registraR, pronto} per state.
    function automatic logic [5:0] ctrl_esp(input logic [3:0] e);
        case (e)
            PREPARA:       return 6'b101000;
            INICIO_RODADA: return 6'b100000;
            PROX_JOGADA:   return 6'b010000;
            PROX_RODADA:   return 6'b000100;
            REGISTRA:      return 6'b000010;
            FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: return 6'b000001;
            default:       return 6'b000000;
        endcase
    endfunction

    task automatic espera(input logic [3:0] e, input int dt, input string nome);
        esperado_t it;
        if (e == PREPARA || e == INICIAL) begin m_g = 0; m_p = 0; m_t = 0; end
        if (e == FIM_GANHOU) m_g = 1;
        if (e == FIM_PERDEU) m_p = 1;
        if (e == FIM_TIMEOUT) begin m_p = 1; m_t = 1; end
        it.vec  = {e, ctrl_esp(e), m_g, m_p, m_t};
        it.dt   = dt;
        it.nome = nome;
        fila.push_back(it);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic inicia(input int hold);
        espera(PREPARA, -1, "prepara");
        espera(INICIO_RODADA, -1, "inicio_rodada");
        espera(ESPERA, -1, "espera");
        iniciar = 1'b1;
        tick(hold);
        iniciar = 1'b0;
        tick(3);
    endtask

    task automatic joga(input bit ig, input bit er, input bit fr, input int hold, input string nome);
        espera(REGISTRA, -1, {nome, "_registra"});
        espera(COMPARA, -1, {nome, "_compara"});
        if (!ig) begin
            espera(FIM_PERDEU, -1, {nome, "_perdeu"});
        end else if (er && fr) begin
            espera(FIM_GANHOU, -1, {nome, "_ganhou"});
        end else if (er) begin
            espera(PROX_RODADA, -1, {nome, "_prox_rodada"});
            espera(INICIO_RODADA, -1, {nome, "_inicio_rodada"});
            espera(ESPERA, -1, {nome, "_espera"});
        end else begin
            espera(PROX_JOGADA, -1, {nome, "_prox_jogada"});
            espera(ESPERA, -1, {nome, "_espera"});
        end
        igual  = ig;
        eir    = er;
        fim_r  = fr;
        jogada = 1'b1;
        tick(hold);
        jogada = 1'b0;
        tick(4);
    endtask

    // Monitor: every change of db_estado is one DUT response to be scored.
    logic [3:0]  anterior = 4'hF;
    int          ultimo = 0;
    logic [12:0] obs;
    esperado_t   exp_it;

    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            if (db_estado !== anterior) begin
                obs = {db_estado, zeraE, contaE, zeraR, contaR, registraR, pronto, ganhou, perdeu, db_timeout};
                checks++;
                if (fila.size() == 0) begin
                    failures++;
                    $display("FAIL transicao_inesperada: estado=%h vec=%b, none expected", db_estado, obs);
                end else begin
                    exp_it = fila.pop_front();
                    if (obs !== exp_it.vec || (exp_it.dt >= 0 && (ciclo - ultimo) != exp_it.dt)) begin
                        failures++;
                        $display("FAIL %s: got vec=%b dt=%0d, expected vec=%b dt=%0d",
                                 exp_it.nome, obs, ciclo - ultimo, exp_it.vec, exp_it.dt);
                    end
                end
                anterior = db_estado;
                ultimo   = ciclo;
            end
        end
    end

    initial begin
        espera(INICIAL, -1, "reset_inicial");
        tick(2);
        reset = 1'b1;
        tick(1);

        // Game 1: long iniciar, long first press, then a wrong move at rodada 2 jogada 2.
        inicia(10);
        joga(1, 1, 0, 10, "r1_j1");
        joga(1, 0, 0, 3, "r2_j1");
        joga(0, 0, 0, 3, "r2_j2_errada");

        // Game 2: flags cleared by PREPARA, then a win on the final rodada.
        inicia(1);
        joga(1, 1, 0, 3, "g2_r1_j1");
        joga(1, 0, 0, 3, "g2_r2_j1");
        joga(1, 1, 1, 3, "g2_r2_j2_final");

        // Game 3: reset pulse while waiting in ESPERA.
        inicia(2);
        espera(INICIAL, -1, "reset_meio_jogo");
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
        inicia(1);

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        // No press: timeout after exactly 20 cycles in ESPERA.
        joga(1, 1, 0, 3, "t1_r1_j1");
        joga(1, 0, 0, 3, "t1_r2_j1");
        espera(FIM_TIMEOUT, 20, "timeout_20_ciclos");
        tick(25);

        // Press landing on the last cycle before timeout: jp wins.
        inicia(1);
        joga(1, 1, 0, 3, "t2_r1_j1");
        joga(1, 0, 0, 3, "t2_r2_j1");
        tick(16);
        espera(REGISTRA, 20, "jp_ciclo_19");
        espera(COMPARA, -1, "jp_ciclo_19_compara");
        espera(FIM_PERDEU, -1, "jp_ciclo_19_perdeu");
        igual  = 1'b0;
        jogada = 1'b1;
        tick(3);
        jogada = 1'b0;
        tick(4);
`else
        // Without the timer ESPERA waits indefinitely.
        tick(100);
        checks++;
        if (db_estado !== ESPERA || db_timeout !== 1'b0) begin
            failures++;
            $display("FAIL espera_sem_timeout: estado=%h db_timeout=%b, expected estado=3 db_timeout=0",
                     db_estado, db_timeout);
        end
`endif

        tick(5);
        checks++;
        if (fila.size() != 0) begin
            failures++;
            $display("FAIL respostas_pendentes: %0d expected transitions never seen, required 0", fila.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
